// File: rtl/layer_pkg.sv
// Shared constants and FSM state type for the layer output collector.
package layer_pkg;

    localparam int WIDTH = 16;
    localparam int M     = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

endpackage

// File: rtl/collector_buf.sv
// Frame buffer: synchronous write, registered read-before-write readback.
module collector_buf
    import layer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d, rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last entry read as zero when DEPTH is not a power of two.
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/layer_out_collector.sv
// Collects one frame of layer outputs, reports the argmax, and
// offers registered readback of the stored frame.
module layer_out_collector
    import layer_pkg::*;
#(
    parameter int M     = layer_pkg::M,
    parameter int WIDTH = layer_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [$clog2(M)-1:0] r_index,
    output logic [WIDTH-1:0]     r_max,
    input  logic [$clog2(M)-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [7:0]           frames_done
);

    localparam int AW = $clog2(M);
    localparam logic [AW-1:0] LAST = AW'(M - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [7:0]      frames_q, frames_d;
    logic            live_q;
    logic            xfer;

    assign xfer = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        max_d    = max_q;
        frames_d = frames_q;
        s_ready  = 1'b0;
        r_valid  = 1'b0;
        unique case (state_q)
            COLLECT: begin
                s_ready = live_q;
                if (xfer) begin
                    // Strict compare keeps the lowest index on ties.
                    if (cnt_q == '0 || $signed(data_in) > $signed(max_q)) begin
                        max_d = data_in;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RESULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    state_d  = COLLECT;
                    frames_d = frames_q + 8'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // live_q holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            idx_q    <= '0;
            max_q    <= '0;
            frames_q <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            frames_q <= frames_d;
            live_q   <= 1'b1;
        end
    end

    assign r_index     = idx_q;
    assign r_max       = max_q;
    assign frames_done = frames_q;

    collector_buf #(
        .DEPTH(M),
        .WIDTH(WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (reset),
        .we     (xfer),
        .wr_addr(cnt_q),
        .wr_data(data_in),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_layer_out_collector.sv
// Directed and table-driven bench for layer_out_collector (M=8, plus an M=6 copy).
module tb_layer_out_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] data_in;
    logic        r_valid;
    logic        r_ready;
    logic [2:0]  r_index;
    logic [15:0] r_max;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  frames_done;

    logic        s6_ready;
    logic        r6_valid;
    logic [2:0]  r6_index;
    logic [15:0] r6_max;
    logic [15:0] rd6_data;
    logic [7:0]  frames6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    layer_out_collector #(.M(8), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .data_in(data_in), .r_valid(r_valid), .r_ready(r_ready),
        .r_index(r_index), .r_max(r_max), .rd_addr(rd_addr),
        .rd_data(rd_data), .frames_done(frames_done)
    );

    layer_out_collector #(.M(6), .WIDTH(16)) dut6 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s6_ready),
        .data_in(data_in), .r_valid(r6_valid), .r_ready(1'b1),
        .r_index(r6_index), .r_max(r6_max), .rd_addr(rd_addr),
        .rd_data(rd6_data), .frames_done(frames6)
    );

    typedef struct {
        int d[8];
        int idx;
        int mx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int gap);
        int g;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        data_in = 16'(d);
        s_valid = 1'b1;
        g = 0;
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) check("push_timeout", int'(s_ready), 1);
        @(posedge clk);
    endtask

    task automatic get_result(input int eidx, input int emx, input int dly,
                              input int eframes);
        int g;
        @(negedge clk);
        s_valid = 1'b0;
        g = 0;
        while (!r_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("r_valid", int'(r_valid), 1);
        check("s_ready_in_result", int'(s_ready), 0);
        check("r_index", int'(r_index), eidx);
        check("r_max", int'($signed(r_max)), emx);
        repeat (dly) @(negedge clk);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("s_ready_after_hs", int'(s_ready), 1);
        check("r_valid_after_hs", int'(r_valid), 0);
        check("frames_done", int'(frames_done), eframes);
    endtask

    initial begin
        int fr;
        int f0;
        int rnd[8];
        int bi;
        int bm;

        vecs[0].d = '{5, -3, 9, 9, 0, 2, 1, 7};
        vecs[0].idx = 2; vecs[0].mx = 9;
        vecs[1].d = '{-8, -2, -5, -2, -9, -7, -3, -6};
        vecs[1].idx = 1; vecs[1].mx = -2;
        vecs[2].d = '{4, 4, 4, 4, 4, 4, 4, 4};
        vecs[2].idx = 0; vecs[2].mx = 4;
        vecs[3].d = '{-32768, 0, 100, -1, 3, 99, 100, 32767};
        vecs[3].idx = 7; vecs[3].mx = 32767;
        vecs[4].d = '{32767, -32768, 32767, 0, 1, 2, 3, 4};
        vecs[4].idx = 0; vecs[4].mx = 32767;

        reset = 1'b0;
        s_valid = 1'b0;
        r_ready = 1'b0;
        data_in = '0;
        rd_addr = '0;

        repeat (3) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_r_valid", int'(r_valid), 0);
        check("rst_frames", int'(frames_done), 0);
        check("rst_r_max", int'(r_max), 0);
        check("rst_r_index", int'(r_index), 0);
        check("rst_rd_data", int'(rd_data), 0);
        reset = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", int'(s_ready), 1);

        fr = 0;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) push(vecs[v].d[i], 0);
            fr++;
            get_result(vecs[v].idx, vecs[v].mx, 0, fr);
        end

        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            @(negedge clk);
            check("readback_v4", int'($signed(rd_data)), vecs[4].d[a]);
        end

        // Stall: result held with upstream still pushing.
        for (int i = 0; i < 8; i++) push(vecs[0].d[i], 0);
        @(negedge clk);
        data_in = 16'h1234;
        s_valid = 1'b1;
        r_ready = 1'b0;
        rd_addr = 3'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0 || c == 19) begin
                check("stall_s_ready", int'(s_ready), 0);
                check("stall_r_index", int'(r_index), 2);
                check("stall_r_max", int'($signed(r_max)), 9);
                check("stall_buf0", int'($signed(rd_data)), 5);
            end
        end
        s_valid = 1'b0;
        fr++;
        get_result(2, 9, 0, fr);
        @(negedge clk);
        check("frames_once", int'(frames_done), fr);

        // Reset mid-frame, then a fresh frame.
        for (int i = 0; i < 4; i++) push(10 * (i + 1), 0);
        @(negedge clk);
        s_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_s_ready", int'(s_ready), 0);
        check("midrst_frames", int'(frames_done), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_s_ready_up", int'(s_ready), 1);
        for (int i = 0; i < 8; i++) push(i + 1, 0);
        fr = 1;
        get_result(7, 8, 0, fr);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            @(negedge clk);
            check("readback_1to8", int'(rd_data), a + 1);
            check("readback_m6", int'(rd6_data),
                  (a == 0) ? 8 : (a <= 5) ? a + 1 : 0);
        end

        // Random frames; frames_done must wrap through 255 -> 0.
        f0 = fr;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0)
                    rnd[i] = int'($urandom_range(0, 65535)) - 32768;
                else
                    rnd[i] = int'($urandom_range(0, 12)) - 6;
            end
            bi = 0;
            bm = rnd[0];
            for (int i = 1; i < 8; i++) begin
                if (rnd[i] > bm) begin
                    bm = rnd[i];
                    bi = i;
                end
            end
            for (int i = 0; i < 8; i++) push(rnd[i], int'($urandom_range(0, 2)));
            get_result(bi, bm, int'($urandom_range(0, 2)), (f0 + f + 1) % 256);
        end
        check("frames_wrapped", int'(frames_done), f0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
